icache_nway: RTL

- Parametrised N-way set-associative instruction cache between the IFU fetch port and the AXI read bridge.
- Serves 32-bit instruction words on a valid/ready request/response handshake.
- Refills whole multi-word lines via a burst read channel.
- Picks victims by per-set saturating age counters and supports a fence.i-style flush of all lines.

---
 rtl/icache_nway_if.sv | 43 ++++
 rtl/icache_nway.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_nway_if                                                              |
// | Fetch, response, flush and refill-bridge signals of the N-way I-cache.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface icache_nway_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              flush_req;
    logic              flush_done;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_rlast;
    logic              mem_rerr;

    // Cache side
    modport slave (
        input  req_valid, req_addr, resp_ready, flush_req,
               mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_rerr,
        output req_ready, resp_valid, resp_data, resp_err, flush_done,
               mem_req_valid, mem_req_addr
    );

    // IFU plus bridge side
    modport master (
        output req_valid, req_addr, resp_ready, flush_req,
               mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_rerr,
        input  req_ready, resp_valid, resp_data, resp_err, flush_done,
               mem_req_valid, mem_req_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_nway                                                                 |
// | N-way set-associative instruction cache with burst refill and full flush.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module icache_nway #(
    parameter int ADDR_W     = 64,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int AGE_W      = 3
) (
    input  logic         clk,
    input  logic         rst,
    icache_nway_if.slave bus
);
    localparam int OFF    = $clog2(LINE_WORDS) + 2;
    localparam int IDX    = $clog2(SETS);
    localparam int LINE_W = ADDR_W - OFF;
    localparam int TAG_W  = ADDR_W - OFF - IDX;
    localparam int WOFF_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W  = $clog2(LINE_WORDS) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOOKUP      = 3'd1,
        REFILL_REQ  = 3'd2,
        REFILL_DATA = 3'd3,
        RESP        = 3'd4,
        FLUSH       = 3'd5
    } state_t;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    // Storage arrays; only valid and age carry reset
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]  valid_q [SETS];
    ages_t            age_q   [SETS];

    state_t            state_q;
    logic [LINE_W-1:0] line_q;
    logic [WOFF_W-1:0] woff_q;
    logic [WAY_W-1:0]  way_q;
    logic              hit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [31:0]       cap_q;
    logic              pend_q;
    logic              resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic              flush_done_q;

    logic [IDX-1:0]    w_in_idx;
    logic [TAG_W-1:0]  w_in_tag;
    logic [WOFF_W-1:0] w_in_woff;
    logic [IDX-1:0]    w_q_idx;
    logic [TAG_W-1:0]  w_q_tag;
    logic              w_unused;

    assign w_in_idx = bus.req_addr[OFF+IDX-1:OFF];
    assign w_in_tag = bus.req_addr[ADDR_W-1:OFF+IDX];
    assign w_q_idx  = line_q[IDX-1:0];
    assign w_q_tag  = line_q[LINE_W-1:IDX];
    assign w_unused = ^bus.req_addr[1:0];

    generate
        if (LINE_WORDS > 1) begin : g_woff_field
            assign w_in_woff = bus.req_addr[OFF-1:2];
        end else begin : g_woff_none
            assign w_in_woff = '0;
        end
    endgenerate

    // Lookup happens against the incoming address so the hit response is registered
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAY_W-1:0] w_vic_way;
    logic [AGE_W-1:0] w_max_age;
    logic [31:0]      w_hit_word;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_vic_way = '0;
        w_max_age = age_q[w_in_idx][0];
        for (int i = 1; i < WAYS; i++) begin
            if (age_q[w_in_idx][i] > w_max_age) begin
                w_max_age = age_q[w_in_idx][i];
                w_vic_way = WAY_W'(i);
            end
        end
        // Descending scan: the last match is the lowest index
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[w_in_idx][i] && (tag_q[i][w_in_idx] == w_in_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!valid_q[w_in_idx][i]) begin
                w_vic_way = WAY_W'(i);
            end
        end
    end

    assign w_hit_word = data_q[w_hit_way][w_in_idx][w_in_woff];

    function automatic ages_t age_touch(input ages_t a, input logic [WAYS-1:0] v,
                                        input logic [WAY_W-1:0] w);
        ages_t r;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == w) begin
                r[i] = '0;
            end else if (v[i] && (a[i] != AGE_MAX)) begin
                r[i] = a[i] + 1'b1;
            end else begin
                r[i] = a[i];
            end
        end
        return r;
    endfunction

    logic w_beat;
    logic w_in_range;
    logic w_beat_we;
    logic w_tgt;
    logic w_err_now;
    logic w_tag_we;

    assign w_beat     = (state_q == REFILL_DATA) && bus.mem_rvalid;
    assign w_in_range = (cnt_q < CNT_END);
    assign w_beat_we  = w_beat && w_in_range;
    assign w_tgt      = w_in_range && (cnt_q[WOFF_W-1:0] == woff_q);
    // A burst that ends on any beat but the last expected one is a short line
    assign w_err_now  = err_q || bus.mem_rerr || (bus.mem_rlast && (cnt_q != CNT_LAST));
    assign w_tag_we   = w_beat && bus.mem_rlast && !w_err_now;

    always_ff @(posedge clk) begin
        if (w_beat_we) begin
            data_q[way_q][w_q_idx][cnt_q[WOFF_W-1:0]] <= bus.mem_rdata;
        end
        if (w_tag_we) begin
            tag_q[way_q][w_q_idx] <= w_q_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            line_q          <= '0;
            woff_q          <= '0;
            way_q           <= '0;
            hit_q           <= 1'b0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            cap_q           <= '0;
            pend_q          <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            flush_done_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= '0;
            end
        end else begin
            flush_done_q <= 1'b0;
            if (bus.flush_req) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        flush_done_q <= 1'b1;
                        state_q      <= FLUSH;
                    end else if (bus.req_valid) begin
                        line_q  <= bus.req_addr[ADDR_W-1:OFF];
                        woff_q  <= w_in_woff;
                        hit_q   <= w_hit;
                        way_q   <= w_hit ? w_hit_way : w_vic_way;
                        state_q <= LOOKUP;
                        if (w_hit) begin
                            resp_valid_q      <= 1'b1;
                            resp_data_q       <= w_hit_word;
                            age_q[w_in_idx]   <= age_touch(age_q[w_in_idx], valid_q[w_in_idx], w_hit_way);
                        end
                    end
                end
                LOOKUP: begin
                    if (hit_q) begin
                        if (bus.resp_ready) begin
                            resp_valid_q <= 1'b0;
                            resp_data_q  <= '0;
                            state_q      <= IDLE;
                        end
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {line_q, {OFF{1'b0}}};
                        state_q         <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_addr_q  <= '0;
                        cnt_q           <= '0;
                        err_q           <= 1'b0;
                        cap_q           <= '0;
                        state_q         <= REFILL_DATA;
                    end
                end
                REFILL_DATA: begin
                    if (bus.mem_rvalid) begin
                        if (w_in_range) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (bus.mem_rerr) begin
                            err_q <= 1'b1;
                        end
                        if (w_tgt) begin
                            cap_q <= bus.mem_rdata;
                        end
                        if (bus.mem_rlast) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= w_tgt ? bus.mem_rdata : cap_q;
                            resp_err_q   <= w_err_now;
                            state_q      <= RESP;
                            if (w_err_now) begin
                                valid_q[w_q_idx][way_q] <= 1'b0;
                            end else begin
                                valid_q[w_q_idx][way_q] <= 1'b1;
                                age_q[w_q_idx] <= age_touch(age_q[w_q_idx], valid_q[w_q_idx], way_q);
                            end
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                FLUSH: begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_q[s] <= '0;
                        age_q[s]   <= '0;
                    end
                    // A flush request landing here queues a second flush
                    pend_q  <= bus.flush_req;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = (state_q == IDLE) && !pend_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.flush_done    = flush_done_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
endmodule
`default_nettype wire
